// File: rtl/cond_flag_stage_if.sv
// cond_flag_stage_if: op, ALU and writeback signals between the ALU stage and cond_flag_stage
//   in_valid, cond[3:0], flag_w[1:0], pcs, reg_w, mem_w, alu_result[N-1:0], alu_flags[3:0] : upstream -> stage
//   flags[3:0], cond_ex, out_valid, result_q[N-1:0], pc_src_q, reg_write_q, mem_write_q   : stage -> downstream
interface cond_flag_stage_if #(parameter int N = 8);
   logic         in_valid;
   logic [3:0]   cond;
   logic [1:0]   flag_w;
   logic         pcs;
   logic         reg_w;
   logic         mem_w;
   logic [N-1:0] alu_result;
   logic [3:0]   alu_flags;
   logic [3:0]   flags;
   logic         cond_ex;
   logic         out_valid;
   logic [N-1:0] result_q;
   logic         pc_src_q;
   logic         reg_write_q;
   logic         mem_write_q;
   modport master (
      output in_valid, cond, flag_w, pcs, reg_w, mem_w, alu_result, alu_flags,
      input  flags, cond_ex, out_valid, result_q, pc_src_q, reg_write_q, mem_write_q
   );
   modport slave (
      input  in_valid, cond, flag_w, pcs, reg_w, mem_w, alu_result, alu_flags,
      output flags, cond_ex, out_valid, result_q, pc_src_q, reg_write_q, mem_write_q
   );
endinterface

// File: rtl/cond_flag_stage.sv
// cond_flag_stage: NZCV flag register, condition evaluation and gated writeback register
//   clk, reset (sync, active-high) : plain ports
//   bus (slave)                    : op controls and ALU outputs in, flags/cond_ex/writeback fields out
module cond_flag_stage #(
   parameter int N = 8
) (
   input logic              clk,
   input logic              reset,
   cond_flag_stage_if.slave bus
);
   logic [3:0]   r_flags;
   logic         r_valid;
   logic [N-1:0] r_result;
   logic         r_pc_src;
   logic         r_reg_write;
   logic         r_mem_write;
   logic         w_base;
   logic         w_pass;
   logic         w_ex;
   logic         w_n, w_z, w_c, w_v;
   assign {w_n, w_z, w_c, w_v} = r_flags;
   // Codes come in true/inverted pairs on cond[0]; 111x is always-pass.
   always_comb begin
      w_base = 1'b1;
      case (bus.cond[3:1])
         3'd0: w_base = w_z;
         3'd1: w_base = w_c;
         3'd2: w_base = w_n;
         3'd3: w_base = w_v;
         3'd4: w_base = ~w_z & w_c;
         3'd5: w_base = w_n == w_v;
         3'd6: w_base = ~w_z & (w_n == w_v);
         default: w_base = 1'b1;
      endcase
      w_pass = (bus.cond[3:1] == 3'b111) ? 1'b1 : w_base ^ bus.cond[0];
   end
   assign w_ex = w_pass & bus.in_valid;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_flags     <= 4'b0000;
         r_valid     <= 1'b0;
         r_result    <= '0;
         r_pc_src    <= 1'b0;
         r_reg_write <= 1'b0;
         r_mem_write <= 1'b0;
      end else begin
         r_valid     <= bus.in_valid;
         r_pc_src    <= bus.pcs & w_ex;
         r_reg_write <= bus.reg_w & w_ex;
         r_mem_write <= bus.mem_w & w_ex;
         if (bus.in_valid) r_result <= bus.alu_result;
         if (bus.flag_w[1] & w_ex) r_flags[3:2] <= bus.alu_flags[3:2];
         if (bus.flag_w[0] & w_ex) r_flags[1:0] <= bus.alu_flags[1:0];
      end
   end
   assign bus.flags       = r_flags;
   assign bus.cond_ex     = w_ex;
   assign bus.out_valid   = r_valid;
   assign bus.result_q    = r_result;
   assign bus.pc_src_q    = r_pc_src;
   assign bus.reg_write_q = r_reg_write;
   assign bus.mem_write_q = r_mem_write;
endmodule
